// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/cond_neg.sv
// Conditional two's-complement negator: q = en ? -d : d.
module cond_neg #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Negate only when requested; width-generic so one cell serves operands and results.
  assign q = en ? (~d + W'(1)) : d;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start_i; MTHI/MTLO writes accepted
// ST_BUSY | one shift-add or restoring-divide step per cycle, Width steps
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int Width = MD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int CntW = $clog2(Width);

  md_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  logic             is_div_q;
  logic             neg_res_q;   // product / quotient sign
  logic             neg_rem_q;   // remainder sign (dividend sign)
  logic             div_zero_q;
  // multiply: multiplicand magnitude; divide: raw dividend for the /0 result
  logic [Width-1:0] opa_q;
  logic [Width-1:0] magb_q;
  // multiply: {partial high, multiplier/low product}; divide: {remainder, dividend/quotient}
  logic [Width-1:0] work_hi_q;
  logic [Width-1:0] work_lo_q;

  md_op_e           op_e;
  logic             op_is_div;
  logic             op_signed;
  logic             sign_a;
  logic             sign_b;
  logic [Width-1:0] mag_a;
  logic [Width-1:0] mag_b;

  logic [Width:0]     mul_sum;
  logic [2*Width-1:0] mul_nxt;
  logic [Width:0]     div_shift;
  logic [Width:0]     div_diff;
  logic               div_ge;
  logic [Width-1:0]   div_hi_nxt;
  logic [Width-1:0]   div_lo_nxt;
  logic [2*Width-1:0] prod_fix;
  logic [Width-1:0]   quo_fix;
  logic [Width-1:0]   rem_fix;
  logic               last_step;

  assign op_e      = md_op_e'(op_i);
  assign op_is_div = (op_e == OP_DIV) || (op_e == OP_DIVU);
  assign op_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign sign_a    = op_signed & a_i[Width-1];
  assign sign_b    = op_signed & b_i[Width-1];

  cond_neg #(.W(Width)) u_mag_a (.en(sign_a), .d(a_i), .q(mag_a));
  cond_neg #(.W(Width)) u_mag_b (.en(sign_b), .d(b_i), .q(mag_b));

  // Shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
  always_comb begin
    mul_sum = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? opa_q : '0)};
    mul_nxt = {mul_sum, work_lo_q[Width-1:1]};
  end

  // Restoring divide step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    div_shift  = {work_hi_q, work_lo_q[Width-1]};
    div_diff   = div_shift - {1'b0, magb_q};
    div_ge     = ~div_diff[Width];
    div_hi_nxt = div_ge ? div_diff[Width-1:0] : div_shift[Width-1:0];
    div_lo_nxt = {work_lo_q[Width-2:0], div_ge};
  end

  cond_neg #(.W(2*Width)) u_fix_prod (.en(neg_res_q), .d(mul_nxt),    .q(prod_fix));
  cond_neg #(.W(Width))   u_fix_quo  (.en(neg_res_q), .d(div_lo_nxt), .q(quo_fix));
  cond_neg #(.W(Width))   u_fix_rem  (.en(neg_rem_q), .d(div_hi_nxt), .q(rem_fix));

  assign last_step = (cnt_q == CntW'(Width - 1));
  assign busy_o    = (state_q == ST_BUSY);

  // Sequencer, operand latch, iteration datapath and HI/LO architectural state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opa_q      <= '0;
      magb_q     <= '0;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      hi_o       <= '0;
      lo_o       <= '0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hi_we_i) hi_o <= wdata_i;
          if (lo_we_i) lo_o <= wdata_i;
          if (start_i && !flush_i) begin
            state_q    <= ST_BUSY;
            cnt_q      <= '0;
            is_div_q   <= op_is_div;
            neg_res_q  <= sign_a ^ sign_b;
            neg_rem_q  <= sign_a;
            div_zero_q <= op_is_div && (b_i == '0);
            magb_q     <= mag_b;
            work_hi_q  <= '0;
            if (op_is_div) begin
              opa_q     <= a_i;
              work_lo_q <= mag_a;
            end else begin
              opa_q     <= mag_a;
              work_lo_q <= mag_b;
            end
          end
        end
        ST_BUSY: begin
          if (flush_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (is_div_q) begin
              work_hi_q <= div_hi_nxt;
              work_lo_q <= div_lo_nxt;
            end else begin
              work_hi_q <= mul_nxt[2*Width-1:Width];
              work_lo_q <= mul_nxt[Width-1:0];
            end
            if (last_step) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              done_o  <= 1'b1;
              if (!is_div_q) begin
                hi_o <= prod_fix[2*Width-1:Width];
                lo_o <= prod_fix[Width-1:0];
              end else if (div_zero_q) begin
                // Divide by zero: fixed result, no sign fix-up.
                hi_o <= opa_q;
                lo_o <= '1;
              end else begin
                hi_o <= rem_fix;
                lo_o <= quo_fix;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit for MULT, MULTU, DIV and DIVU, with architectural HI/LO registers.
- Sits beside the execute stage and takes the same forwarded operands as the ALU.
- Results are read by MFHI/MFLO in execute; MTHI/MTLO write HI/LO directly.
- busy_o feeds the hazard unit, which stalls any HI/LO access while an operation is in flight.

Parameters:
- Width, 32, operand/HI/LO width; iteration count equals Width.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  launch operation op_i on a_i/b_i
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a_i  in  Width  rs operand (multiplicand / dividend)
- b_i  in  Width  rt operand (multiplier / divisor)
- hi_we_i  in  1  MTHI write enable
- lo_we_i  in  1  MTLO write enable
- wdata_i  in  Width  MTHI/MTLO data
- flush_i  in  1  abort in-flight operation (exception / pipeline flush)
- busy_o  out  1  operation in flight
- done_o  out  1  one-cycle pulse when HI/LO receive a result
- hi_o  out  Width  HI register
- lo_o  out  Width  LO register

Behaviour:
- Reset (async, rst_ni=0): state IDLE, counter 0; hi_o, lo_o, busy_o, done_o all 0; working registers cleared.
- States and transitions:
  - IDLE: start_i accepted here; operands latched; go to BUSY with counter 0.
  - BUSY: one iteration per cycle; counter increments; after iteration Width-1, HI/LO written and go to IDLE.
- Latency: start accepted in cycle t; busy_o=1 in cycles t+1..t+Width; HI/LO hold the result and done_o=1 in cycle t+Width+1. busy_o is registered (state != IDLE).
- Signed ops:
  - Latch operand magnitudes and result signs at start.
  - Product sign = sign(a) xor sign(b); quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - Final fix-up negates the 2*Width product, quotient or remainder as required.
- Multiply: shift-add over Width iterations producing a 2*Width result; HI = upper Width bits, LO = lower Width bits.
- Divide: restoring, one quotient bit per iteration; LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): LO = all ones, HI = a_i as latched. This overrides sign fix-up.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wrap, no trap).
- start_i while BUSY: ignored; the in-flight operation is unaffected.
- hi_we_i / lo_we_i in IDLE: HI/LO take wdata_i at the edge. Both may be set in the same cycle.
- hi_we_i / lo_we_i while BUSY: dropped. The hazard unit must stall them.
- start_i together with hi_we_i/lo_we_i in IDLE: the write lands, the operation launches, and the result later overwrites HI/LO.
- flush_i while BUSY: go to IDLE next edge; HI/LO unchanged; no done_o.
- flush_i in the same cycle as start_i: start ignored.
- flush_i in IDLE: no effect. MT writes in the same cycle still land.
- Reset mid-operation: immediate clear; no result is written.

Decomposition:
- Package muldiv_pkg:
  - op enum (MULT/MULTU/DIV/DIVU, 2 bits)
  - state enum (IDLE/BUSY)
  - localparam for counter width, $clog2(Width)
- One natural sub-module: cond_neg, a parameterised-width conditional two's-complement negator. It is instantiated for operand magnitudes (Width) and result fix-up (2*Width and Width).

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at t -> busy_o high t+1..t+32; done_o at t+33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV -5/0 -> LO=0xFFFFFFFF, HI=0xFFFFFFFB.
- MULTU 2x3 started; start_i with DIVU 9/3 at t+5 and lo_we_i=1 with wdata_i=0xAA at t+6 -> both ignored; result HI=0, LO=6 at t+33.
- HI=LO=0x1234 via MTHI/MTLO; start DIVU 100/7; flush_i at t+10 -> busy_o=0 at t+11; no done_o; HI/LO stay 0x1234.
- MULTU in flight; rst_ni low at t+12 -> busy_o, hi_o, lo_o = 0 immediately; after release, a fresh MULTU 4x5 gives LO=20, HI=0.
